// File: rtl/dot_chunk_accumulator_if.sv
// Handshake bundle between the adder-tree front end, the chunk accumulator and its consumer.
interface dot_chunk_accumulator_if;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic [7:0] sum_in;
  logic [3:0] shift_in;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       sat_flag;

  modport master (
    output in_valid, in_last, sum_in, shift_in, out_ready,
    input  in_ready, out_data, out_valid, sat_flag
  );

  modport slave (
    input  in_valid, in_last, sum_in, shift_in, out_ready,
    output in_ready, out_data, out_valid, sat_flag
  );
endinterface

// File: rtl/dot_chunk_accumulator.sv
// Accumulates per-chunk adder-tree sums into a signed dot product, requantizes it to int8
// and queues results behind a valid/ready output, issuing upstream credits via in_ready.
module dot_chunk_accumulator #(
  parameter int TreeLatency = 3,
  parameter int AccWidth    = 16,
  parameter int FifoDepth   = 4
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  dot_chunk_accumulator_if.slave bus
);

  localparam int PtrW = $clog2(FifoDepth);
  localparam int CntW = $clog2(FifoDepth + 1);
  localparam int LifW = $clog2(TreeLatency + 1);
  localparam int CrdW = ((CntW > LifW) ? CntW : LifW) + 1;
  localparam int RqW  = AccWidth + 1;

  localparam logic signed [RqW-1:0] AccMax = {2'b00, {(AccWidth - 1){1'b1}}};
  localparam logic signed [RqW-1:0] AccMin = {2'b11, {(AccWidth - 1){1'b0}}};
  localparam logic signed [RqW-1:0] OutMax = {{(RqW - 7){1'b0}}, 7'h7F};
  localparam logic signed [RqW-1:0] OutMin = {{(RqW - 7){1'b1}}, 7'h00};

  function automatic logic clips(input logic signed [RqW-1:0] v, lo, hi);
    clips = (v < lo) || (v > hi);
  endfunction

  function automatic logic signed [RqW-1:0] clamp(input logic signed [RqW-1:0] v, lo, hi);
    if (v < lo) begin
      clamp = lo;
    end else if (v > hi) begin
      clamp = hi;
    end else begin
      clamp = v;
    end
  endfunction

  logic [TreeLatency-1:0] dl_valid_q, dl_valid_d;
  logic [TreeLatency-1:0] dl_last_q, dl_last_d;
  logic [AccWidth-1:0]    acc_q, acc_d;
  logic [7:0]             mem_q [FifoDepth];
  logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]        count_q, count_d;
  logic                   sat_q, sat_d;

  logic                   take_s, emerge_s, push_s, pop_s;
  logic                   acc_clip_s, rq_clip_s;
  logic [LifW-1:0]        lif_s;
  logic signed [RqW-1:0]  next_wide_s, next_sat_s, rnd_s, rq_wide_s;
  logic [7:0]             rq_data_s;

  // Lasts still inside the tree already own a FIFO slot.
  always_comb begin
    lif_s = {LifW{1'b0}};
    for (int i = 0; i < TreeLatency; i++) begin
      lif_s = lif_s + LifW'(dl_valid_q[i] & dl_last_q[i]);
    end
  end

  assign bus.in_ready  = (CrdW'(count_q) + CrdW'(lif_s)) < CrdW'(FifoDepth);
  assign bus.out_valid = (count_q != {CntW{1'b0}});
  assign bus.out_data  = bus.out_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign bus.sat_flag  = sat_q;

  assign take_s   = bus.in_valid & bus.in_ready;
  assign emerge_s = dl_valid_q[TreeLatency-1];
  assign push_s   = emerge_s & dl_last_q[TreeLatency-1];
  assign pop_s    = bus.out_valid & bus.out_ready;

  // Saturating accumulate, then round-half-up shift and clip to int8.
  always_comb begin
    next_wide_s = $signed({acc_q[AccWidth-1], acc_q})
                + $signed({{(RqW - 8){bus.sum_in[7]}}, bus.sum_in});
    acc_clip_s  = clips(next_wide_s, AccMin, AccMax);
    next_sat_s  = clamp(next_wide_s, AccMin, AccMax);
    if (bus.shift_in == 4'd0) begin
      rnd_s     = {RqW{1'b0}};
      rq_wide_s = next_sat_s;
    end else begin
      rnd_s     = $signed({{(RqW - 1){1'b0}}, 1'b1} << (bus.shift_in - 4'd1));
      rq_wide_s = (next_sat_s + rnd_s) >>> bus.shift_in;
    end
    rq_clip_s = clips(rq_wide_s, OutMin, OutMax);
    rq_data_s = 8'(clamp(rq_wide_s, OutMin, OutMax));
  end

  // Next state for the delay line, accumulator, sticky flag and FIFO bookkeeping.
  always_comb begin
    dl_valid_d = dl_valid_q;
    dl_last_d  = dl_last_q;
    for (int i = TreeLatency - 1; i > 0; i--) begin
      dl_valid_d[i] = dl_valid_q[i-1];
      dl_last_d[i]  = dl_last_q[i-1];
    end
    dl_valid_d[0] = take_s;
    dl_last_d[0]  = take_s & bus.in_last;

    if (emerge_s) begin
      if (dl_last_q[TreeLatency-1]) begin
        acc_d = {AccWidth{1'b0}};
      end else begin
        acc_d = next_sat_s[AccWidth-1:0];
      end
    end else begin
      acc_d = acc_q;
    end

    sat_d    = sat_q | (emerge_s & (acc_clip_s | (push_s & rq_clip_s)));
    wr_ptr_d = push_s ? (wr_ptr_q + PtrW'(1'b1)) : wr_ptr_q;
    rd_ptr_d = pop_s  ? (rd_ptr_q + PtrW'(1'b1)) : rd_ptr_q;

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CntW'(1'b1);
      2'b01:   count_d = count_q - CntW'(1'b1);
      default: count_d = count_q;
    endcase
  end

  // State registers; storage is cleared too so nothing stale survives a reset.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      dl_valid_q <= {TreeLatency{1'b0}};
      dl_last_q  <= {TreeLatency{1'b0}};
      acc_q      <= {AccWidth{1'b0}};
      wr_ptr_q   <= {PtrW{1'b0}};
      rd_ptr_q   <= {PtrW{1'b0}};
      count_q    <= {CntW{1'b0}};
      sat_q      <= 1'b0;
      for (int i = 0; i < FifoDepth; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      dl_valid_q <= dl_valid_d;
      dl_last_q  <= dl_last_d;
      acc_q      <= acc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      sat_q      <= sat_d;
      if (push_s) begin
        mem_q[wr_ptr_q] <= rq_data_s;
      end
    end
  end

endmodule

// File: tb/tb_dot_chunk_accumulator.sv
// Directed vector table, multi-cycle corner sequences and a randomized run checked
// against a transaction-level model of the chunk accumulator.
module tb_dot_chunk_accumulator;
  localparam int TL    = 3;
  localparam int DEPTH = 4;

  typedef struct packed {
    int          n;
    logic [31:0] sums;
    int          sh;
    int          exp;
    int          sat;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dot_chunk_accumulator_if bus ();
  dot_chunk_accumulator_if bus9 ();

  dot_chunk_accumulator #(.TreeLatency(TL), .AccWidth(16), .FifoDepth(DEPTH)) dut (
    .clk_in(clk), .rst_in(rst), .bus(bus)
  );
  dot_chunk_accumulator #(.TreeLatency(TL), .AccWidth(9), .FifoDepth(DEPTH)) dut9 (
    .clk_in(clk), .rst_in(rst), .bus(bus9)
  );

  assign bus9.in_valid  = bus.in_valid;
  assign bus9.in_last   = bus.in_last;
  assign bus9.sum_in    = bus.sum_in;
  assign bus9.shift_in  = bus.shift_in;
  assign bus9.out_ready = bus.out_ready;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] chunk_sum;
  logic [7:0] pipe [TL];
  vec_t       tbl [12];
  int         exp_q [$];
  int         macc, lasts_acc, pops;
  bit         msat;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: actual %0d required %0d", name, act, exp);
  endtask

  function automatic int od();
    return int'($signed(bus.out_data));
  endfunction

  function automatic vec_t mk(int n, int a, int b, int c, int d, int sh, int exp, int sat);
    vec_t v;
    v.n = n; v.sums = {8'(d), 8'(c), 8'(b), 8'(a)};
    v.sh = sh; v.exp = exp; v.sat = sat;
    return v;
  endfunction

  // Emulates the adder tree: a transferred chunk's sum reaches sum_in TL cycles later.
  task automatic tick();
    logic fire;
    fire = bus.in_valid && bus.in_ready;
    @(posedge clk);
    #1;
    for (int i = TL - 1; i > 0; i--) pipe[i] = pipe[i-1];
    pipe[0]    = fire ? chunk_sum : 8'($urandom);
    bus.sum_in = pipe[TL-1];
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.out_ready = 1'b0;
    bus.shift_in = 4'd0; chunk_sum = 8'h00; bus.sum_in = 8'h00;
    for (int i = 0; i < TL; i++) pipe[i] = 8'h00;
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic push_chunk(input int s, input bit last);
    int guard = 0;
    bus.in_valid = 1'b1; bus.in_last = last; chunk_sum = 8'(s);
    while (!bus.in_ready && guard < 50) begin tick(); guard++; end
    check("push_ready_in_time", int'(guard < 50), 1);
    tick();
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 30) begin tick(); lat++; end
  endtask

  task automatic pop_expect(input int exp, input string name);
    int lat;
    wait_valid(lat);
    check(name, od(), exp);
    bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    bus.shift_in = 4'(v.sh);
    for (int k = 0; k < v.n; k++) push_chunk(int'($signed(v.sums[8*k +: 8])), k == v.n - 1);
    wait_valid(lat);
    check($sformatf("vec%0d_latency", idx), lat + 1, TL + 1);
    check($sformatf("vec%0d_data", idx), od(), v.exp);
    check($sformatf("vec%0d_sat", idx), int'(bus.sat_flag), v.sat);
    bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;
    check($sformatf("vec%0d_empty_after_pop", idx), int'(bus.out_valid), 0);
  endtask

  // Reference: whole-chunk arithmetic with clamping, rounding by integer floor shift.
  task automatic model_chunk(input int s, input bit last, input int sh);
    int r;
    macc = macc + s;
    if (macc > 32767) begin macc = 32767; msat = 1'b1; end
    else if (macc < -32768) begin macc = -32768; msat = 1'b1; end
    if (last) begin
      if (sh == 0) r = macc;
      else r = (macc + (1 << (sh - 1))) >>> sh;
      if (r > 127) begin r = 127; msat = 1'b1; end
      else if (r < -128) begin r = -128; msat = 1'b1; end
      exp_q.push_back(r);
      macc = 0;
      lasts_acc++;
    end
  endtask

  task automatic rnd_cycle();
    check("rnd_in_ready", int'(bus.in_ready), int'((lasts_acc - pops) < DEPTH));
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL rnd_unexpected_out: actual %0d required no output", od());
      end else begin
        check("rnd_out", od(), exp_q.pop_front());
      end
      pops++;
    end
    if (bus.in_valid && bus.in_ready)
      model_chunk(int'($signed(chunk_sum)), bus.in_last, int'(bus.shift_in));
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, got, guard, extra;
    bit acc5;

    tbl[0]  = mk(3,   10,   20,  30, 0,  2,   15, 0);
    tbl[1]  = mk(1,   -7,    0,   0, 0,  1,   -3, 0);
    tbl[2]  = mk(1,   -8,    0,   0, 0,  3,   -1, 0);
    tbl[3]  = mk(1,    5,    0,   0, 0,  0,    5, 0);
    tbl[4]  = mk(3,  100,  -50,   3, 0,  0,   53, 0);
    tbl[5]  = mk(2, -128, -128,   0, 0,  4,  -16, 0);
    tbl[6]  = mk(2,  127,  127,   0, 0,  1,  127, 0);
    tbl[7]  = mk(4,    1,    2,   3, 4, 15,    0, 0);
    tbl[8]  = mk(2,  100,  100,   0, 0,  0,  127, 1);
    tbl[9]  = mk(2, -100, -100,   0, 0,  0, -128, 1);
    tbl[10] = mk(1,   -1,    0,   0, 0,  0,   -1, 1);
    tbl[11] = mk(2,   -3,    0,   0, 0,  1,   -1, 1);

    do_reset();
    check("rst_in_ready", int'(bus.in_ready), 1);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_out_data", od(), 0);
    check("rst_sat_flag", int'(bus.sat_flag), 0);

    for (int i = 0; i < 12; i++) run_vec(tbl[i], i);

    do_reset();
    check("sat_cleared_by_reset", int'(bus.sat_flag), 0);

    // Narrow accumulator clips at 255 while the wide one keeps 381.
    bus.shift_in = 4'd2;
    push_chunk(127, 1'b0); push_chunk(127, 1'b0); push_chunk(127, 1'b0); push_chunk(0, 1'b1);
    wait_valid(lat);
    check("acc16_data", od(), 95);
    check("acc16_sat", int'(bus.sat_flag), 0);
    check("acc9_valid", int'(bus9.out_valid), 1);
    check("acc9_data", int'($signed(bus9.out_data)), 64);
    check("acc9_sat", int'(bus9.sat_flag), 1);
    bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;
    check("acc9_empty_after_pop", int'(bus9.out_valid), 0);

    // Backpressure: four credits, fifth held off until a pop.
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("bp_ready_%0d", k), int'(bus.in_ready), 1);
      bus.in_valid = 1'b1; bus.in_last = 1'b1; chunk_sum = 8'(k);
      tick();
    end
    chunk_sum = 8'd5;
    for (int k = 0; k < 6; k++) begin
      check("bp_ready_low", int'(bus.in_ready), 0);
      tick();
    end
    bus.out_ready = 1'b1; got = 0; guard = 0; acc5 = 1'b0;
    while (got < 5 && guard < 40) begin
      if (bus.out_valid) begin check("bp_out_order", od(), got + 1); got++; end
      if (bus.in_valid && bus.in_ready) acc5 = 1'b1;
      tick();
      if (acc5) begin bus.in_valid = 1'b0; bus.in_last = 1'b0; end
      guard++;
    end
    check("bp_out_count", got, 5);
    extra = 0;
    for (int k = 0; k < 6; k++) begin
      if (bus.out_valid) extra++;
      tick();
    end
    check("bp_no_extra_out", extra, 0);
    bus.out_ready = 1'b0;

    // Push and pop in the same cycle with three entries queued.
    do_reset();
    push_chunk(11, 1'b1); push_chunk(12, 1'b1); push_chunk(13, 1'b1); push_chunk(14, 1'b1);
    tick(); tick();
    check("pp_head", od(), 11);
    bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;
    check("pp_ready_count3", int'(bus.in_ready), 1);
    check("pp_valid", int'(bus.out_valid), 1);
    pop_expect(12, "pp_out2");
    pop_expect(13, "pp_out3");
    pop_expect(14, "pp_out4");
    check("pp_empty", int'(bus.out_valid), 0);

    // Reset with a queued result and two chunks inside the tree.
    do_reset();
    push_chunk(9, 1'b1);
    tick(); tick();
    push_chunk(50, 1'b0); push_chunk(60, 1'b0);
    check("mf_held_before_reset", int'(bus.out_valid), 1);
    do_reset();
    check("mf_ready_after_reset", int'(bus.in_ready), 1);
    check("mf_valid_after_reset", int'(bus.out_valid), 0);
    bus.out_ready = 1'b1; extra = 0;
    for (int k = 0; k < 8; k++) begin
      if (bus.out_valid) extra++;
      tick();
    end
    bus.out_ready = 1'b0;
    check("mf_nothing_emitted", extra, 0);
    run_vec(mk(1, 5, 0, 0, 0, 0, 5, 0), 99);

    // Randomized traffic against the reference model.
    do_reset();
    macc = 0; msat = 1'b0; lasts_acc = 0; pops = 0; exp_q.delete();
    for (int ph = 0; ph < 4; ph++) begin
      bus.shift_in = 4'($urandom_range(0, 15));
      for (int c = 0; c < 400; c++) begin
        bus.in_valid  = (c < 390) && ($urandom_range(0, 3) != 0);
        bus.in_last   = ($urandom_range(0, 2) == 0);
        chunk_sum     = 8'($urandom);
        bus.out_ready = ($urandom_range(0, 3) != 0);
        rnd_cycle();
      end
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    for (int c = 0; c < 30; c++) rnd_cycle();
    check("rnd_leftover", exp_q.size(), 0);
    check("rnd_drained", int'(bus.out_valid), 0);
    check("rnd_sat_flag", int'(bus.sat_flag), int'(msat));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
